// File: rtl/gfmul_pkg.sv
// Shared widths, reduction constant and block types for the GCM GF(2^128) multiplier.
package gfmul_pkg;

    localparam int GF_W = 128;

    // Reflected image of x^7 + x^2 + x + 1: bit 127 is x^0.
    localparam logic [GF_W-1:0] GF_R = 128'hE1 << 120;

    typedef logic [GF_W-1:0]   gfBlock_t;
    typedef logic [2*GF_W-2:0] gfWide_t;

endpackage

// File: rtl/gf_clmul.sv
// Combinational 128x128 carry-less multiplier (schoolbook XOR tree), 255-bit product.
module gf_clmul
    import gfmul_pkg::*;
(
    input  gfBlock_t iA,
    input  gfBlock_t iB,
    output gfWide_t  oProd
);

    always_comb begin
        oProd = '0;
        for (int i = 0; i < GF_W; i++) begin
            if (iA[i]) begin
                oProd = oProd ^ ({{(GF_W-1){1'b0}}, iB} << i);
            end
        end
    end

endmodule

// File: rtl/gfmul.sv
// GHASH multiplier: X*H mod x^128+x^7+x^2+x+1, GCM bit-reflected order.
// Optional macro GFMUL_PIPE_EN registers the unreduced product (latency 2 instead of 1).
module gfmul
    import gfmul_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [GF_W-1:0] iCtext,
    input  logic [GF_W-1:0] iHashkey,
    output logic [GF_W-1:0] oResult
);

    gfWide_t  prodComb;
    gfWide_t  prodStage;
    gfBlock_t reduced;

    gf_clmul uClmul (
        .iA    (iCtext),
        .iB    (iHashkey),
        .oProd (prodComb)
    );

    // In the raw product, bit 254 is x^0 and bits [126:0] are x^128..x^254.
    // Each overflow term folds back as x^m * (1+x+x^2+x^7), i.e. a right shift
    // by the set positions of GF_R; the first fold spills at most x^128..x^134,
    // which a second fold clears.
    function automatic gfBlock_t gfReduce(input gfWide_t p);
        logic [GF_W+6:0] ext;
        logic [GF_W+6:0] fold1;
        gfBlock_t        spill;
        gfBlock_t        fold2;
        ext   = {p[GF_W-2:0], 1'b0, 7'b0};
        fold1 = '0;
        for (int s = 0; s < 8; s++) begin
            if (GF_R[GF_W-1-s]) fold1 = fold1 ^ (ext >> s);
        end
        spill = {fold1[6:0], {(GF_W-7){1'b0}}};
        fold2 = '0;
        for (int s = 0; s < 8; s++) begin
            if (GF_R[GF_W-1-s]) fold2 = fold2 ^ (spill >> s);
        end
        return p[2*GF_W-2:GF_W-1] ^ fold1[GF_W+6:7] ^ fold2;
    endfunction

`ifdef GFMUL_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prodStage <= '0;
        else        prodStage <= prodComb;
    end
`else
    assign prodStage = prodComb;
`endif

    assign reduced = gfReduce(prodStage);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) oResult <= '0;
        else        oResult <= reduced;
    end

endmodule

// File: tb/tb_gfmul.sv
// Self-checking bench for gfmul: directed table, streaming, reset corners and a bit-serial reference.
module tb_gfmul;
    import gfmul_pkg::*;

`ifdef GFMUL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [127:0] x;
        logic [127:0] h;
        logic [127:0] expv;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [127:0] iCtext;
    logic [127:0] iHashkey;
    logic [127:0] oResult;

    int errors = 0;
    int checks = 0;

    gfmul dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .iCtext   (iCtext),
        .iHashkey (iHashkey),
        .oResult  (oResult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] refMul(input logic [127:0] x, input logic [127:0] h);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = h;
        for (int i = 127; i >= 0; i--) begin
            if (x[i]) z = z ^ v;
            v = v[0] ? ((v >> 1) ^ 128'hE1000000_00000000_00000000_00000000) : (v >> 1);
        end
        return z;
    endfunction

    task automatic check(input string name, input logic [127:0] exp);
        checks++;
        if (oResult !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, oResult, exp);
        end
    endtask

    vec_t tbl[6];
    vec_t rnd[20];

    initial begin
        tbl[0] = '{128'h80000000_00000000_00000000_00000000, 128'hb83b533708bf535d0aa6e52980d53b78, 128'hb83b533708bf535d0aa6e52980d53b78};
        tbl[1] = '{128'hb83b533708bf535d0aa6e52980d53b78, 128'h80000000_00000000_00000000_00000000, 128'hb83b533708bf535d0aa6e52980d53b78};
        tbl[2] = '{128'h40000000_00000000_00000000_00000000, 128'hb83b533708bf535d0aa6e52980d53b78, 128'h5c1da99b845fa9ae85537294c06a9dbc};
        tbl[3] = '{128'h40000000_00000000_00000000_00000000, 128'h1, 128'he1000000_00000000_00000000_00000000};
        tbl[4] = '{128'h0, 128'hb83b533708bf535d0aa6e52980d53b78, 128'h0};
        tbl[5] = '{128'hdeadbeef_01234567_89abcdef_f00dcafe, 128'h0, 128'h0};

        rst_n    = 1'b0;
        iCtext   = 128'h12345678_9abcdef0_0fedcba9_87654321;
        iHashkey = 128'hb83b533708bf535d0aa6e52980d53b78;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_hold", 128'h0);
        end

        // Release between edges; first product only after full latency.
        @(negedge clk);
        rst_n    = 1'b1;
        iCtext   = tbl[2].x;
        iHashkey = tbl[2].h;
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk); #1;
            check("post_reset_fill", 128'h0);
        end
        @(posedge clk); #1;
        check("post_reset_first", tbl[2].expv);

        for (int i = 0; i < 6; i++) begin
            iCtext   = tbl[i].x;
            iHashkey = tbl[i].h;
            repeat (LAT) @(posedge clk);
            #1;
            check($sformatf("table_%0d", i), tbl[i].expv);
        end

        // Three non-zero directed vectors back-to-back.
        for (int c = 0; c < 3 + LAT - 1; c++) begin
            if (c < 3) begin
                iCtext   = tbl[c + 1].x;
                iHashkey = tbl[c + 1].h;
            end
            @(posedge clk); #1;
            if (c - LAT + 1 >= 0) check($sformatf("stream_%0d", c - LAT + 1), tbl[c - LAT + 2].expv);
        end

        for (int i = 0; i < 20; i++) begin
            rnd[i].x = {$urandom, $urandom, $urandom, $urandom};
            rnd[i].h = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) rnd[i].h = 128'h1;
            if (i == 1) rnd[i].x = 128'hffffffff_ffffffff_ffffffff_ffffffff;
            rnd[i].expv = refMul(rnd[i].x, rnd[i].h);
        end
        for (int c = 0; c < 20 + LAT - 1; c++) begin
            if (c < 20) begin
                iCtext   = rnd[c].x;
                iHashkey = rnd[c].h;
            end
            @(posedge clk); #1;
            if (c - LAT + 1 >= 0) check($sformatf("random_%0d", c - LAT + 1), rnd[c - LAT + 1].expv);
        end

        // Commutativity on a random pair.
        iCtext   = rnd[5].h;
        iHashkey = rnd[5].x;
        repeat (LAT) @(posedge clk);
        #1;
        check("commute", rnd[5].expv);

        // Mid-stream reset clears output at once and drops in-flight products.
        iCtext   = rnd[7].x;
        iHashkey = rnd[7].h;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_reset", 128'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        iCtext   = rnd[8].x;
        iHashkey = rnd[8].h;
        for (int k = 1; k < LAT; k++) begin
            @(posedge clk); #1;
            check("midstream_fill", 128'h0);
        end
        @(posedge clk); #1;
        check("midstream_first", rnd[8].expv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
